// File: rtl/operand_fetch_seq.sv
// MSP430 operand-fetch addressing-mode sequencer: walks source then destination
// addressing modes, steering the address calculator, memory address mux and reads.
module operand_fetch_seq (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [1:0] as,
  input  logic       ad,
  input  logic       bw,
  input  logic       src_cg,
  input  logic       mem_rdy,
  output logic [1:0] mc,
  output logic [1:0] mab_sel,
  output logic       mem_rd,
  output logic       pc_inc,
  output logic       sreg_inc,
  output logic       sreg_inc2,
  output logic       src_stb,
  output logic       dst_stb,
  output logic       busy,
  output logic       done
);

  typedef enum logic [3:0] {
    IDLE  = 4'd0,
    S_EXT = 4'd1,
    S_ADD = 4'd2,
    S_IND = 4'd3,
    S_RD  = 4'd4,
    S_LAT = 4'd5,
    D_EXT = 4'd6,
    D_ADD = 4'd7,
    D_RD  = 4'd8,
    D_LAT = 4'd9,
    DONE  = 4'd10
  } state_t;

  state_t     state_q, state_d;
  logic [1:0] as_q, as_d;
  logic       ad_q, ad_d;
  logic       bw_q, bw_d;
  logic       src_cg_q, src_cg_d;

  // State and captured-mode registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      as_q     <= 2'b00;
      ad_q     <= 1'b0;
      bw_q     <= 1'b0;
      src_cg_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      as_q     <= as_d;
      ad_q     <= ad_d;
      bw_q     <= bw_d;
      src_cg_q <= src_cg_d;
    end
  end

  // Next-state and Moore output decode
  always_comb begin
    state_d   = state_q;
    as_d      = as_q;
    ad_d      = ad_q;
    bw_d      = bw_q;
    src_cg_d  = src_cg_q;
    mc        = 2'd0;
    mab_sel   = 2'd0;
    mem_rd    = 1'b0;
    pc_inc    = 1'b0;
    sreg_inc  = 1'b0;
    sreg_inc2 = 1'b0;
    src_stb   = 1'b0;
    dst_stb   = 1'b0;
    busy      = (state_q != IDLE);
    done      = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          as_d     = as;
          ad_d     = ad;
          bw_d     = bw;
          src_cg_d = src_cg;
          // Entry decisions use the live inputs, identical to what is captured.
          if (src_cg || (as == 2'b00)) begin
            state_d = ad ? D_EXT : DONE;
          end else if (as == 2'b01) begin
            state_d = S_EXT;
          end else begin
            state_d = S_IND;
          end
        end else begin
          state_d = IDLE;
        end
      end
      S_EXT: begin
        mab_sel = 2'd0;
        mem_rd  = 1'b1;
        if (mem_rdy) begin
          pc_inc  = 1'b1;
          state_d = S_ADD;
        end else begin
          state_d = S_EXT;
        end
      end
      S_ADD: begin
        mc      = 2'd2;
        state_d = S_RD;
      end
      S_RD: begin
        mab_sel = 2'd1;
        mem_rd  = 1'b1;
        state_d = mem_rdy ? S_LAT : S_RD;
      end
      S_IND: begin
        mab_sel = 2'd2;
        mem_rd  = 1'b1;
        state_d = mem_rdy ? S_LAT : S_IND;
      end
      S_LAT: begin
        src_stb = 1'b1;
        if (as_q == 2'b11) begin
          sreg_inc  = 1'b1;
          sreg_inc2 = ~bw_q;
        end else begin
          sreg_inc  = 1'b0;
          sreg_inc2 = 1'b0;
        end
        state_d = ad_q ? D_EXT : DONE;
      end
      D_EXT: begin
        mab_sel = 2'd0;
        mem_rd  = 1'b1;
        if (mem_rdy) begin
          pc_inc  = 1'b1;
          state_d = D_ADD;
        end else begin
          state_d = D_EXT;
        end
      end
      D_ADD: begin
        mc      = 2'd3;
        state_d = D_RD;
      end
      D_RD: begin
        mab_sel = 2'd1;
        mem_rd  = 1'b1;
        state_d = mem_rdy ? D_LAT : D_RD;
      end
      D_LAT: begin
        dst_stb = 1'b1;
        state_d = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    // Pulses are suppressed in the reset cycle so nothing downstream acts on them.
    if (!rst_n) begin
      pc_inc    = 1'b0;
      sreg_inc  = 1'b0;
      sreg_inc2 = 1'b0;
      src_stb   = 1'b0;
      dst_stb   = 1'b0;
      done      = 1'b0;
    end else begin
      state_d = state_d;
    end
  end

endmodule

// File: tb/tb_operand_fetch_seq.sv
// Scoreboard bench for operand_fetch_seq: per-cycle expected output vectors are
// queued by the stimulus and checked by an independent monitor on the falling edge.
module tb_operand_fetch_seq;

  logic       clk = 1'b0;
  logic       rst_n, start, ad, bw, src_cg, mem_rdy;
  logic [1:0] as;
  logic [1:0] mc, mab_sel;
  logic       mem_rd, pc_inc, sreg_inc, sreg_inc2, src_stb, dst_stb, busy, done;

  typedef struct {
    logic [11:0] exp;
    string       nm;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  operand_fetch_seq dut (
    .clk(clk), .rst_n(rst_n), .start(start), .as(as), .ad(ad), .bw(bw),
    .src_cg(src_cg), .mem_rdy(mem_rdy), .mc(mc), .mab_sel(mab_sel),
    .mem_rd(mem_rd), .pc_inc(pc_inc), .sreg_inc(sreg_inc), .sreg_inc2(sreg_inc2),
    .src_stb(src_stb), .dst_stb(dst_stb), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // {mc, mab_sel, mem_rd, pc_inc, sreg_inc, sreg_inc2, src_stb, dst_stb, busy, done}
  function automatic logic [11:0] ev(input logic [1:0] m, input logic [1:0] ms,
                                     input logic rd, input logic pc, input logic si,
                                     input logic si2, input logic ss, input logic ds,
                                     input logic b, input logic d);
    return {m, ms, rd, pc, si, si2, ss, ds, b, d};
  endfunction

  localparam logic [11:0] IDL = 12'd0;

  task automatic step(input logic [11:0] e, input string nm);
    exp_t x;
    x.exp = e;
    x.nm  = nm;
    q.push_back(x);
    @(posedge clk);
    #1;
  endtask

  // Monitor: compares the DUT output vector against the queued expectation.
  initial begin
    exp_t x;
    logic [11:0] act;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        x   = q.pop_front();
        act = {mc, mab_sel, mem_rd, pc_inc, sreg_inc, sreg_inc2, src_stb, dst_stb, busy, done};
        n_cmp++;
        if (act !== x.exp) begin
          n_bad++;
          $display("FAIL %s: got %b expected %b (mc,mab,rd,pc,si,si2,ss,ds,busy,done)",
                   x.nm, act, x.exp);
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; as = 2'b00; ad = 1'b0; bw = 1'b0;
    src_cg = 1'b0; mem_rdy = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    step(IDL, "reset_cycle");
    rst_n = 1'b1;
    step(IDL, "reset_idle");

    // reg/reg
    start = 1'b1; as = 2'b00; ad = 1'b0;
    step(IDL, "rr_c0");
    start = 1'b0;
    step(ev(2'd0,2'd0,0,0,0,0,0,0,1,1), "rr_done_c1");
    step(IDL, "rr_idle_c2");

    // indexed/indexed, start during DONE ignored, start right after accepted
    start = 1'b1; as = 2'b01; ad = 1'b1;
    step(IDL, "ii_c0");
    start = 1'b0; as = 2'b00; ad = 1'b0;
    step(ev(2'd0,2'd0,1,1,0,0,0,0,1,0), "ii_sext_c1");
    step(ev(2'd2,2'd0,0,0,0,0,0,0,1,0), "ii_sadd_c2");
    step(ev(2'd0,2'd1,1,0,0,0,0,0,1,0), "ii_srd_c3");
    step(ev(2'd0,2'd0,0,0,0,0,1,0,1,0), "ii_slat_c4");
    step(ev(2'd0,2'd0,1,1,0,0,0,0,1,0), "ii_dext_c5");
    step(ev(2'd3,2'd0,0,0,0,0,0,0,1,0), "ii_dadd_c6");
    step(ev(2'd0,2'd1,1,0,0,0,0,0,1,0), "ii_drd_c7");
    step(ev(2'd0,2'd0,0,0,0,0,0,1,1,0), "ii_dlat_c8");
    start = 1'b1; as = 2'b01; ad = 1'b1;
    step(ev(2'd0,2'd0,0,0,0,0,0,0,1,1), "ii_done_c9");
    as = 2'b00; ad = 1'b0;
    step(IDL, "start_in_done_ignored");
    start = 1'b0;
    step(ev(2'd0,2'd0,0,0,0,0,0,0,1,1), "start_after_done");
    step(IDL, "idle_after_restart");

    // indirect autoinc, word then byte; inputs change after capture
    for (int k = 0; k < 2; k++) begin
      start = 1'b1; as = 2'b11; ad = 1'b0; bw = k[0];
      step(IDL, "ind_c0");
      start = 1'b0; as = 2'b01; ad = 1'b1; bw = ~k[0];
      step(ev(2'd0,2'd2,1,0,0,0,0,0,1,0), "ind_sind_c1");
      step(ev(2'd0,2'd0,0,0,1,~k[0],1,0,1,0), "ind_slat_c2");
      step(ev(2'd0,2'd0,0,0,0,0,0,0,1,1), "ind_done_c3");
      step(IDL, "ind_idle_c4");
    end
    bw = 1'b0;

    // plain indirect: no autoincrement
    start = 1'b1; as = 2'b10; ad = 1'b0;
    step(IDL, "ind10_c0");
    start = 1'b0;
    step(ev(2'd0,2'd2,1,0,0,0,0,0,1,0), "ind10_sind");
    step(ev(2'd0,2'd0,0,0,0,0,1,0,1,0), "ind10_slat_noinc");
    step(ev(2'd0,2'd0,0,0,0,0,0,0,1,1), "ind10_done");

    // indexed source with memory wait states
    start = 1'b1; as = 2'b01; ad = 1'b0;
    step(IDL, "ws_c0");
    start = 1'b0; mem_rdy = 1'b0;
    step(ev(2'd0,2'd0,1,0,0,0,0,0,1,0), "ws_sext_wait1");
    step(ev(2'd0,2'd0,1,0,0,0,0,0,1,0), "ws_sext_wait2");
    mem_rdy = 1'b1;
    step(ev(2'd0,2'd0,1,1,0,0,0,0,1,0), "ws_sext_accept");
    step(ev(2'd2,2'd0,0,0,0,0,0,0,1,0), "ws_sadd_c4");
    mem_rdy = 1'b0;
    step(ev(2'd0,2'd1,1,0,0,0,0,0,1,0), "ws_srd_wait");
    mem_rdy = 1'b1;
    step(ev(2'd0,2'd1,1,0,0,0,0,0,1,0), "ws_srd_accept");
    step(ev(2'd0,2'd0,0,0,0,0,1,0,1,0), "ws_slat");
    step(ev(2'd0,2'd0,0,0,0,0,0,0,1,1), "ws_done");

    // constant generator source, indexed destination, start while busy
    start = 1'b1; src_cg = 1'b1; as = 2'b11; ad = 1'b1;
    step(IDL, "cg_c0");
    start = 1'b1; src_cg = 1'b0; as = 2'b01; ad = 1'b0;
    step(ev(2'd0,2'd0,1,1,0,0,0,0,1,0), "cg_dext_c1");
    start = 1'b0;
    step(ev(2'd3,2'd0,0,0,0,0,0,0,1,0), "cg_dadd_c2");
    step(ev(2'd0,2'd1,1,0,0,0,0,0,1,0), "cg_drd_c3");
    step(ev(2'd0,2'd0,0,0,0,0,0,1,1,0), "cg_dlat_c4");
    step(ev(2'd0,2'd0,0,0,0,0,0,0,1,1), "cg_done_c5");
    step(IDL, "cg_idle_c6");

    // reset mid-operation in S_RD
    start = 1'b1; as = 2'b01; ad = 1'b1;
    step(IDL, "rst_c0");
    start = 1'b0;
    step(ev(2'd0,2'd0,1,1,0,0,0,0,1,0), "rst_sext_c1");
    step(ev(2'd2,2'd0,0,0,0,0,0,0,1,0), "rst_sadd_c2");
    rst_n = 1'b0;
    step(ev(2'd0,2'd1,1,0,0,0,0,0,1,0), "rst_srd_c3");
    rst_n = 1'b1;
    step(IDL, "rst_idle_c4");
    step(IDL, "rst_idle_c5");

    // reset while S_EXT accepts: pc_inc suppressed
    start = 1'b1; as = 2'b01; ad = 1'b0;
    step(IDL, "rst2_c0");
    start = 1'b0; rst_n = 1'b0;
    step(ev(2'd0,2'd0,1,0,0,0,0,0,1,0), "rst2_sext_nopc");
    rst_n = 1'b1;
    step(IDL, "rst2_idle");

    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    if (q.size() > 0) begin
      n_bad++;
      $display("FAIL drain: %0d expectations left, expected 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/operand_fetch_seq.md
# operand_fetch_seq

Addressing-mode sequencer for the MSP430 operand-fetch path. On each decoded instruction it walks the source and destination addressing modes, drives the `MC` select of the address calculator, and steers the memory address bus. It also issues memory reads, PC and source-register increments, and operand-valid strobes. It sits between the instruction decoder and the address calculator / memory interface.

## Interface
No parameters.
- clk  in  1  core clock; all state updates on rising edge
- rst_n  in  1  synchronous active-low reset
- start  in  1  decoder pulse: new instruction; sampled only in IDLE
- as  in  2  source addressing mode (00 reg, 01 indexed, 10 indirect, 11 indirect autoinc); captured at start
- ad  in  1  destination mode (0 reg, 1 indexed); captured at start
- bw  in  1  byte op; captured at start
- src_cg  in  1  source is constant generator, so no source fetch; captured at start
- mem_rdy  in  1  memory accepts the read this cycle
- mc  out  2  address-calculator select: 0 idle, 2 Sout+MDB, 3 Dout+MDB; 1 never driven
- mab_sel  out  2  address mux: 0 PC, 1 CALC_OUT, 2 Sout, 3 Dout
- mem_rd  out  1  memory read request
- pc_inc  out  1  PC += 2 (one pulse per accepted extension-word read)
- sreg_inc  out  1  source register increment pulse
- sreg_inc2  out  1  increment amount: 1 = +2, 0 = +1; valid with sreg_inc
- src_stb  out  1  MDB holds source operand this cycle
- dst_stb  out  1  MDB holds destination operand this cycle
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle completion pulse

## Operation
- Reset: state IDLE. All outputs 0, captured mode registers 0.
- States: IDLE, S_EXT, S_ADD, S_IND, S_RD, S_LAT, D_EXT, D_ADD, D_RD, D_LAT, DONE.
- IDLE + start: capture as/ad/bw/src_cg, then go to the source entry state.
  - Source entry state:
    - src_cg=1 or as=00: go to the destination entry.
    - as=01: go to S_EXT.
    - as=10 or 11: go to S_IND.
  - Destination entry: ad=1 goes to D_EXT; ad=0 goes to DONE.
- S_EXT: mab_sel=0, mem_rd=1. On mem_rdy, pc_inc=1 and go to S_ADD; otherwise hold.
- S_ADD: mc=2 (calculator samples extension word on MDB). Go to S_RD.
- S_RD: mab_sel=1, mem_rd=1. On mem_rdy go to S_LAT; otherwise hold.
- S_IND: mab_sel=2, mem_rd=1. On mem_rdy go to S_LAT; otherwise hold.
- S_LAT: src_stb=1. If captured as=11, also sreg_inc=1 and sreg_inc2=~bw. Then go to the destination entry.
- D_EXT, D_ADD, D_RD, D_LAT: mirror S_EXT, S_ADD, S_RD, S_LAT with these differences:
  - D_ADD drives mc=3.
  - D_LAT drives dst_stb; sreg_inc is never asserted.
- DONE: done=1, then go to IDLE.
- start while busy is ignored. Inputs changing after capture have no effect.
- Outputs are decoded from state (Moore), except pc_inc, which is state & mem_rdy.
- mc=0 in every state except S_ADD and D_ADD.

## Timing
- Memory read data is valid on MDB the cycle after the accepted request (mem_rd & mem_rdy).
- Calculator output is valid the cycle after mc is driven; S_RD and D_RD use it as the address.
- Cycle counts, with start in cycle 0 and mem_rdy always high:
  - reg/reg: DONE in cycle 1; busy low in cycle 2.
  - indexed source: S_EXT 1, S_ADD 2, S_RD 3, S_LAT 4.
  - indirect source: S_IND 1, S_LAT 2.
  - indexed destination adds 4 cycles; DONE follows.
  - indexed/indexed: done in cycle 9.
- Each mem_rdy=0 cycle in a read state adds exactly one cycle:
  - mem_rd stays high and mab_sel is held.
  - No pc_inc until acceptance.
- rst_n low in any cycle: the next cycle is IDLE with all outputs 0. No pulses (pc_inc, sreg_inc, strobes, done) are asserted in or after the reset cycle.
- A start in the same cycle as DONE is ignored. A start in the cycle after DONE is accepted.

## Test plan
- Reset mid-op: as=01/ad=1 start, rst_n=0 in cycle 3 -> cycle 4 IDLE, busy=0, mc=0, no done.
- as=00, ad=0, start -> done=1 in cycle 1; no mem_rd, mc always 0.
- as=01, ad=1, mem_rdy=1 -> the following, with done in cycle 9:
  - mem_rd in cycles 1, 3, 5, 7.
  - pc_inc in cycles 1 and 5.
  - mc=2 in cycle 2, mc=3 in cycle 6.
  - mab_sel=1 in cycles 3 and 7.
  - src_stb in cycle 4, dst_stb in cycle 8.
- as=11, bw=0, then bw=1; ad=0 -> S_IND in cycle 1 (mab_sel=2); cycle 2 src_stb=1, sreg_inc=1, sreg_inc2=1 then 0; done in cycle 3.
- as=01, mem_rdy low in cycles 1-2 -> S_EXT held 3 cycles, a single pc_inc in cycle 3, mc=2 in cycle 4.
- src_cg=1, as=11, ad=1 -> no source fetch, no sreg_inc; D_EXT in cycle 1; a start pulse during busy is ignored.
